// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared op codes and FSM states for the data memory arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_SWAP  = 2'b10,
        OP_ILL   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        RDWAIT  = 3'd2,
        SWAP_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Ops whose first memory access is a read whose data must be captured.
    function automatic logic op_reads(input op_t op);
        return (op == OP_READ) || (op == OP_SWAP);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester req/ack bundle and data memory bundle
interface dmem_req_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, op, addr, wdata, input ack, rdata);
    modport slave  (input req, op, addr, wdata, output ack, rdata);
endinterface

interface dmem_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              en;
    logic              we;
    logic [ADDR_W-3:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output en, we, addr, wdata, input rdata);
    modport slave  (input en, we, addr, wdata, output rdata);
endinterface

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin pick; the last_grant register lives in the caller
module rr_arbiter_2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       winner
);

    always_comb begin
        winner = 1'b0;
        grant  = 2'b00;
        if (req0 && req1) begin
            winner = ~last_grant;
        end else if (req1) begin
            winner = 1'b1;
        end
        if (req0 || req1) begin
            grant = winner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - sequences a 1-cycle synchronous data memory between CPU and loader ports
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic       clk,
    input  logic       rst,
    dmem_req_if.slave  p0,
    dmem_req_if.slave  p1,
    dmem_mem_if.master mem,
    output logic       busy,
    output logic       grant_id
);

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              lat_id;
    op_t               lat_op;
    logic [ADDR_W-3:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;

    logic [1:0]        arb_grant;
    logic              arb_winner;
    logic              arb_any;
    logic              latch;

    // Byte-lane bits of the requester addresses carry no meaning for a word memory.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, p0.addr[1:0], p1.addr[1:0]};

    rr_arbiter_2 u_arb (
        .req0       (p0.req),
        .req1       (p1.req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .winner     (arb_winner)
    );

    assign arb_any = |arb_grant;
    assign latch   = (state == IDLE) && arb_any;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Every output is decoded from state and latched fields, never from a live req.
    always_comb begin
        state_nxt = state;
        mem.en    = 1'b0;
        mem.we    = 1'b0;
        mem.addr  = lat_addr;
        mem.wdata = lat_wdata;
        p0.ack    = 1'b0;
        p1.ack    = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (lat_op == OP_ILL) begin
                    state_nxt = DONE;
                end else if (lat_op == OP_WRITE) begin
                    mem.en    = 1'b1;
                    mem.we    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    mem.en    = 1'b1;
                    state_nxt = RDWAIT;
                end
            end
            RDWAIT: begin
                state_nxt = (lat_op == OP_SWAP) ? SWAP_WR : DONE;
            end
            SWAP_WR: begin
                mem.en    = 1'b1;
                mem.we    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                p0.ack    = ~lat_id;
                p1.ack    = lat_id;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Requester fields are copied once at the grant; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            lat_id     <= 1'b0;
            lat_op     <= OP_READ;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else if (latch) begin
            last_grant <= arb_winner;
            lat_id     <= arb_winner;
            if (arb_winner) begin
                lat_op    <= op_t'(p1.op);
                lat_addr  <= p1.addr[ADDR_W-1:2];
                lat_wdata <= p1.wdata;
            end else begin
                lat_op    <= op_t'(p0.op);
                lat_addr  <= p0.addr[ADDR_W-1:2];
                lat_wdata <= p0.wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata0 <= '0;
            rdata1 <= '0;
        end else if (state == RDWAIT && op_reads(lat_op)) begin
            if (lat_id) begin
                rdata1 <= mem.rdata;
            end else begin
                rdata0 <= mem.rdata;
            end
        end
    end

    assign p0.rdata = rdata0;
    assign p1.rdata = rdata1;
    assign busy     = (state != IDLE);
    assign grant_id = lat_id;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences the shared data memory (word-addressed, 1-cycle synchronous read) between two requesters.
- Port 0 is the CPU datapath memory stage (load/store/swap-to-memory); port 1 is the loader/DMA port used to preload or dump memory.
- Round-robin arbitration, req/ack handshake, and an atomic read-then-write SWAP that locks out the other port for its duration.
- Sits between the requesters and the data memory array; drives the stall/busy signals the CPU uses.

Parameters:
- ADDR_W, 32, byte-address width of requester ports.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 request; held with op/addr/wdata until ack.
- p0_op  in  2  00 read, 01 write, 10 swap, 11 illegal.
- p0_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- p0_wdata  in  DATA_W  write/swap data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_W  read/swap-old data; valid with ack, held until the next port 0 ack.
- p1_req, p1_op, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  write enable (qualified by mem_en).
- mem_addr  out  ADDR_W-2  word address = addr[ADDR_W-1:2].
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en with mem_we=0.
- busy  out  1  state != IDLE.
- grant_id  out  1  port being served; meaningful only while busy.

Behaviour:
- Reset values:
  - state=IDLE.
  - All acks, mem_en, mem_we and busy = 0.
  - grant_id=0; p0_rdata=p1_rdata=0.
  - last_grant=1, so port 0 wins the first tie.
- States: IDLE, ISSUE, RDWAIT, SWAP_WR, DONE.
- IDLE: if any req, latch winner id, op, addr and wdata → ISSUE. Otherwise stay.
  - Sole requester wins.
  - Both requesting: winner = !last_grant.
  - last_grant updates to the winner at this latch.
- ISSUE: mem_en=1, mem_addr=latched addr.
  - op 01: mem_we=1, mem_wdata=latched wdata → DONE.
  - op 00 or 10: mem_we=0 → RDWAIT.
  - op 11: mem_en=0, no access → DONE; rdata is not updated.
- RDWAIT: capture mem_rdata into the winner's rdata register.
  - op 00 → DONE.
  - op 10 → SWAP_WR.
- SWAP_WR: mem_en=1, mem_we=1, same addr, latched wdata → DONE.
- DONE: winner's ack=1 for exactly this cycle → IDLE.
- Latency, with req first sampled in cycle T:
  - Write/illegal: ack at T+2.
  - Read: ack at T+3.
  - Swap: ack at T+4; rdata = pre-swap memory value.
- Handshake:
  - Requester keeps req, op, addr and wdata stable until it sees ack.
  - Requester drops req in the cycle after ack unless issuing a new request.
  - req still high in the cycle after ack is arbitrated as a new request.
  - Changes to inputs after latch are ignored; the latched copies are used.
- Locking: the non-winner is never served between latch and DONE, including across a swap's two memory accesses.
- Fairness: with both ports requesting continuously, grants strictly alternate. A waiting port is served within one other transaction.
- Back-to-back: the earliest new latch is the cycle after DONE, so there is at least one IDLE cycle between transactions.
- Reset mid-operation:
  - Transaction aborted with no ack.
  - mem_en/mem_we are 0 from the cycle after rst is sampled.
  - If the write phase was not yet issued, memory is unchanged.
  - last_grant returns to 1.
  - Requester must re-present its request.
- No output depends combinationally on any req input. All outputs are decoded from registered state and latched fields.

Decomposition:
- Package dmem_arb_pkg:
  - Op codes OP_READ=2'b00, OP_WRITE=2'b01, OP_SWAP=2'b10, OP_ILL=2'b11.
  - State enum (IDLE, ISSUE, RDWAIT, SWAP_WR, DONE).
- Sub-module rr_arbiter_2: combinational pick from {req0, req1, last_grant} producing a one-hot grant and winner id.
  - The last_grant register stays in the parent.
- FSM, latched fields and rdata registers live in dmem_arbiter.

Test Plan:
- Reset, then p0 read addr 0x10 with memory word 4 = 0x1234 → mem_en at T+1 with mem_addr=4 and mem_we=0; p0_ack at T+3 with p0_rdata=0x1234; p1_ack stays 0.
- p1 write addr 0x20, data 0xDEADBEEF → mem_en=mem_we=1, mem_addr=8 at T+1; p1_ack at T+2; a following p0 read of 0x20 returns 0xDEADBEEF.
- p0 swap addr 0x08, wdata 0xAA, old word 0x02 → read at T+1, write 0xAA at T+3; p0_ack at T+4 with p0_rdata=0x02; p1 request raised at T+1 is not acked before T+6.
- Both ports request writes continuously from reset → grant order p0, p1, p0, p1; acks alternate; busy drops for exactly one cycle between transactions.
- p0 read issued, rst asserted in the RDWAIT cycle → no p0_ack; mem_en=0 next cycle; busy=0; p0_rdata=0; re-request completes normally.
- p0 op=11 → p0_ack at T+2; mem_en never asserted; p0_rdata unchanged from its previous value.
